// File: rtl/drive_cmd_scheduler.sv
// Drive-command frame scheduler: merges IR commands, keepalive resends and a link watchdog
// into start/code requests for the UART JSON transmitter, with a minimum inter-frame gap.
module drive_cmd_scheduler #(
   parameter int unsigned GAP_CYCLES        = 50_000,
   parameter int unsigned RESEND_CYCLES     = 25_000_000,
   parameter int unsigned WD_CYCLES         = 100_000_000,
   parameter int unsigned TX_TIMEOUT_CYCLES = 1_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   input  logic [2:0]  cmd_code,
   input  logic        tx_done,
   output logic        tx_start,
   output logic [2:0]  tx_code,
   output logic        busy,
   output logic [2:0]  cur_code,
   output logic        wd_stop,
   output logic        tx_err,
   output logic [15:0] frame_count
);

   localparam logic [2:0] CodeStop = 3'b000;
   localparam logic [2:0] CodeMax  = 3'b100;

   typedef enum logic [1:0] {StIdle, StStart, StWaitDone, StGap} state_e;

   state_e      state_q, state_d;
   logic        pend_q, pend_d;
   logic [2:0]  pend_code_q, pend_code_d;
   logic [2:0]  tx_code_q, tx_code_d;
   logic [2:0]  cur_code_q, cur_code_d;
   logic        wd_stop_q, wd_stop_d;
   logic        tx_err_q, tx_err_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic [31:0] wd_cnt_q, wd_cnt_d;
   logic [31:0] ka_cnt_q, ka_cnt_d;
   // Shared by WAIT_DONE (tx timeout) and GAP (inter-frame gap); cleared on each transition.
   logic [31:0] tmr_q, tmr_d;

   logic cmd_ok;
   logic wd_fire;
   logic ka_req;

   assign cmd_ok  = cmd_valid && (cmd_code <= CodeMax);
   assign wd_fire = (wd_cnt_q == WD_CYCLES - 1) && (cur_code_q != CodeStop) && !pend_q && !cmd_ok;
   assign ka_req  = (RESEND_CYCLES != 0) && (ka_cnt_q == RESEND_CYCLES - 1) && !pend_q;

   always_comb begin
      state_d     = state_q;
      pend_d      = pend_q;
      pend_code_d = pend_code_q;
      tx_code_d   = tx_code_q;
      cur_code_d  = cur_code_q;
      wd_stop_d   = wd_stop_q;
      tx_err_d    = tx_err_q;
      frame_cnt_d = frame_cnt_q;
      tmr_d       = tmr_q;
      ka_cnt_d    = '0;
      wd_cnt_d    = (wd_cnt_q == WD_CYCLES) ? wd_cnt_q : wd_cnt_q + 32'd1;

      unique case (state_q)
         StIdle: begin
            if (pend_q) begin
               state_d   = StStart;
               tx_code_d = pend_code_q;
               pend_d    = 1'b0;
            end else if (ka_req) begin
               state_d   = StStart;
               tx_code_d = cur_code_q;
            end else begin
               ka_cnt_d = ka_cnt_q + 32'd1;
            end
         end
         StStart: begin
            cur_code_d  = tx_code_q;
            frame_cnt_d = frame_cnt_q + 16'd1;
            tmr_d       = '0;
            state_d     = StWaitDone;
         end
         StWaitDone: begin
            if (tx_done) begin
               tmr_d   = '0;
               state_d = StGap;
            end else if (tmr_q == TX_TIMEOUT_CYCLES - 1) begin
               tx_err_d = 1'b1;
               tmr_d    = '0;
               state_d  = StGap;
            end else begin
               tmr_d = tmr_q + 32'd1;
            end
         end
         StGap: begin
            if (tmr_q == GAP_CYCLES - 1) begin
               tmr_d   = '0;
               state_d = StIdle;
            end else begin
               tmr_d = tmr_q + 32'd1;
            end
         end
         default: state_d = StIdle;
      endcase

      if (wd_fire) begin
         pend_d      = 1'b1;
         pend_code_d = CodeStop;
         wd_stop_d   = 1'b1;
      end

      // Evaluated last so a command landing on the IDLE consume cycle re-arms the buffer.
      if (cmd_ok) begin
         wd_cnt_d  = '0;
         wd_stop_d = 1'b0;
         if ((cmd_code != cur_code_q) || pend_q) begin
            pend_d      = 1'b1;
            pend_code_d = cmd_code;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         pend_q      <= 1'b0;
         pend_code_q <= CodeStop;
         tx_code_q   <= CodeStop;
         cur_code_q  <= CodeStop;
         wd_stop_q   <= 1'b0;
         tx_err_q    <= 1'b0;
         frame_cnt_q <= '0;
         wd_cnt_q    <= '0;
         ka_cnt_q    <= '0;
         tmr_q       <= '0;
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         pend_code_q <= pend_code_d;
         tx_code_q   <= tx_code_d;
         cur_code_q  <= cur_code_d;
         wd_stop_q   <= wd_stop_d;
         tx_err_q    <= tx_err_d;
         frame_cnt_q <= frame_cnt_d;
         wd_cnt_q    <= wd_cnt_d;
         ka_cnt_q    <= ka_cnt_d;
         tmr_q       <= tmr_d;
      end
   end

   assign tx_start    = (state_q == StStart);
   assign busy        = (state_q != StIdle);
   assign tx_code     = tx_code_q;
   assign cur_code    = cur_code_q;
   assign wd_stop     = wd_stop_q;
   assign tx_err      = tx_err_q;
   assign frame_count = frame_cnt_q;

endmodule
